// File: rtl/div_issue_seq.sv
// div_issue_seq: issues operands to a combinational divider, holds them LAT cycles,
// then captures the selected result and flags into a valid/ready response register.
module div_issue_seq #(
    parameter int N    = 32,
    parameter int LAT  = 2,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [N-1:0]    req_x,
    input  logic [N-1:0]    req_y,
    input  logic [1:0]      req_op,
    input  logic [TAGW-1:0] req_tag,
    output logic [N-1:0]    div_x,
    output logic [N-1:0]    div_y,
    output logic            div_signed,
    input  logic [N-1:0]    div_q,
    input  logic [N-1:0]    div_r,
    input  logic            div_d0,
    input  logic            div_ov,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_data,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_dz,
    output logic            rsp_ov,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [N-1:0]    div_x_q, div_y_q, rsp_data_q;
    logic            div_signed_q, rem_q, rsp_valid_q, rsp_dz_q, rsp_ov_q;
    logic [TAGW-1:0] tag_q, rsp_tag_q;
    logic            accept;
    // A draining response frees the slot in the same cycle, so issue can be back-to-back.
    assign req_ready  = ~flush & (state_q == IDLE | (state_q == RESP & rsp_ready));
    assign accept     = req_valid & req_ready;
    assign busy       = state_q != IDLE;
    assign div_x      = div_x_q;
    assign div_y      = div_y_q;
    assign div_signed = div_signed_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_dz     = rsp_dz_q;
    assign rsp_ov     = rsp_ov_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_x_q      <= '0;
            div_y_q      <= '0;
            div_signed_q <= 1'b0;
            rem_q        <= 1'b0;
            tag_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_dz_q     <= 1'b0;
            rsp_ov_q     <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: ;
                WAIT:
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                    else begin
                        rsp_data_q  <= rem_q ? div_r : div_q;
                        rsp_dz_q    <= div_d0;
                        rsp_ov_q    <= div_ov & div_signed_q;
                        rsp_tag_q   <= tag_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                RESP:
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                div_x_q      <= req_x;
                div_y_q      <= req_y;
                div_signed_q <= req_op[0];
                rem_q        <= req_op[1];
                tag_q        <= req_tag;
                cnt_q        <= 4'(LAT - 1);
                state_q      <= WAIT;
            end
        end
    end
endmodule

// File: tb/tb_div_issue_seq.sv
// tb_div_issue_seq: directed table plus corner sequences against a behavioural divider.
module tb_div_issue_seq;
    localparam int N = 32, TAGW = 5;
    logic clk = 0, rst = 1, flush = 0;
    logic req_valid = 0, req_valid1 = 0, rsp_ready = 0;
    logic [N-1:0] req_x = 0, req_y = 0;
    logic [1:0] req_op = 0;
    logic [TAGW-1:0] req_tag = 0;
    logic req_ready, div_signed, div_d0, div_ov, rsp_valid, rsp_dz, rsp_ov, busy;
    logic [N-1:0] div_x, div_y, div_q, div_r, rsp_data;
    logic [TAGW-1:0] rsp_tag;
    logic req_ready1, div_signed1, div_d01, div_ov1, rsp_valid1, rsp_dz1, rsp_ov1, busy1;
    logic [N-1:0] div_x1, div_y1, div_q1, div_r1, rsp_data1;
    logic [TAGW-1:0] rsp_tag1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    div_issue_seq #(.N(N), .LAT(2), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_op(req_op), .req_tag(req_tag),
        .div_x(div_x), .div_y(div_y), .div_signed(div_signed),
        .div_q(div_q), .div_r(div_r), .div_d0(div_d0), .div_ov(div_ov),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_dz(rsp_dz), .rsp_ov(rsp_ov), .busy(busy));

    div_issue_seq #(.N(N), .LAT(1), .TAGW(TAGW)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_x(req_x), .req_y(req_y), .req_op(req_op), .req_tag(req_tag),
        .div_x(div_x1), .div_y(div_y1), .div_signed(div_signed1),
        .div_q(div_q1), .div_r(div_r1), .div_d0(div_d01), .div_ov(div_ov1),
        .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1),
        .rsp_dz(rsp_dz1), .rsp_ov(rsp_ov1), .busy(busy1));

    // Divider model: {q, r, d0, ov}; raw ov ignores signedness so the sequencer's masking is exercised.
    function automatic logic [2*N+1:0] divm(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        logic [N-1:0] q, r;
        logic d0, ov;
        d0 = (y == 0);
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        if (d0) begin
            q = s ? (x[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'hFFFF_FFFF;
            r = x;
        end else if (ov && s) begin
            q = x;
            r = 0;
        end else if (s) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r, d0, ov};
    endfunction

    assign {div_q, div_r, div_d0, div_ov} = divm(div_x, div_y, div_signed);
    assign {div_q1, div_r1, div_d01, div_ov1} = divm(div_x1, div_y1, div_signed1);

    typedef struct {
        logic [1:0]      op;
        logic [N-1:0]    x, y;
        logic [TAGW-1:0] tag;
        logic [N-1:0]    data;
        logic            dz, ov;
    } vec_t;
    vec_t vecs[10];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [N-1:0] x, input logic [N-1:0] y, input logic [TAGW-1:0] tag);
        req_op = op; req_x = x; req_y = y; req_tag = tag; req_valid = 1;
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'd100,        32'd7,          5'd3,  32'd14,         1'b0, 1'b0};
        vecs[1] = '{2'b11, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[2] = '{2'b01, 32'd5,          32'd0,          5'd5,  32'h7FFF_FFFF,  1'b1, 1'b0};
        vecs[3] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  32'h8000_0000,  1'b0, 1'b1};
        vecs[4] = '{2'b00, 32'd5,          32'd0,          5'd7,  32'hFFFF_FFFF,  1'b1, 1'b0};
        vecs[5] = '{2'b10, 32'd100,        32'd7,          5'd8,  32'd2,          1'b0, 1'b0};
        vecs[6] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          1'b0, 1'b0};
        vecs[7] = '{2'b01, 32'hFFFF_FF9C,  32'd7,          5'd10, 32'hFFFF_FFF2,  1'b0, 1'b0};
        vecs[8] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1'b0, 1'b1};
        vecs[9] = '{2'b10, 32'd5,          32'd0,          5'd31, 32'd5,          1'b1, 1'b0};

        step; step;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_x", div_x, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        rst = 0;
        #1 chk("rst_req_ready", req_ready, 1);

        rsp_ready = 1;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            issue(v.op, v.x, v.y, v.tag);
            #1 chk($sformatf("v%0d_req_ready", i), req_ready, 1);
            step;
            req_valid = 0;
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_div_x", i), div_x, v.x);
            chk($sformatf("v%0d_div_y", i), div_y, v.y);
            chk($sformatf("v%0d_div_signed", i), div_signed, v.op[0]);
            chk($sformatf("v%0d_early_valid", i), rsp_valid, 0);
            step;
            chk($sformatf("v%0d_wait_valid", i), rsp_valid, 0);
            chk($sformatf("v%0d_wait_signed", i), div_signed, v.op[0]);
            step;
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_data", i), rsp_data, v.data);
            chk($sformatf("v%0d_rsp_tag", i), rsp_tag, v.tag);
            chk($sformatf("v%0d_rsp_dz", i), rsp_dz, v.dz);
            chk($sformatf("v%0d_rsp_ov", i), rsp_ov, v.ov);
            step;
            chk($sformatf("v%0d_drained", i), rsp_valid, 0);
            chk($sformatf("v%0d_idle", i), busy, 0);
        end

        // Backpressure, then drain and accept on the same edge.
        rsp_ready = 0;
        issue(2'b00, 32'd100, 32'd7, 5'd3);
        step; step; step;
        issue(2'b01, 32'hFFFF_FF9C, 32'd7, 5'd9);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'd14);
            chk("bp_rsp_tag", rsp_tag, 3);
            chk("bp_div_x_hold", div_x, 32'd100);
            step;
        end
        rsp_ready = 1;
        #1 chk("b2b_req_ready", req_ready, 1);
        step;
        req_valid = 0;
        chk("b2b_valid_low", rsp_valid, 0);
        chk("b2b_busy", busy, 1);
        chk("b2b_div_x", div_x, 32'hFFFF_FF9C);
        chk("b2b_signed", div_signed, 1);
        step;
        chk("b2b_wait", rsp_valid, 0);
        step;
        chk("b2b_rsp_valid", rsp_valid, 1);
        chk("b2b_rsp_data", rsp_data, 32'hFFFF_FFF2);
        chk("b2b_rsp_tag", rsp_tag, 9);
        step;
        chk("b2b_drained", busy, 0);

        // Flush mid-WAIT.
        issue(2'b00, 32'd50, 32'd5, 5'd1);
        step;
        req_valid = 0;
        flush = 1;
        #1 chk("fw_req_ready", req_ready, 0);
        step;
        flush = 0;
        chk("fw_busy", busy, 0);
        chk("fw_div_x_kept", div_x, 32'd50);
        #1 chk("fw_req_ready_after", req_ready, 1);
        step; step;
        chk("fw_no_rsp", rsp_valid, 0);

        // Flush in RESP while the consumer is ready.
        issue(2'b00, 32'd50, 32'd5, 5'd2);
        step;
        req_valid = 0;
        step; step;
        chk("fr_rsp_valid", rsp_valid, 1);
        flush = 1;
        step;
        flush = 0;
        chk("fr_dropped", rsp_valid, 0);
        chk("fr_busy", busy, 0);
        #1 chk("fr_req_ready", req_ready, 1);

        // Reset mid-WAIT.
        issue(2'b01, 32'd77, 32'd3, 5'd12);
        step;
        req_valid = 0;
        rst = 1;
        step;
        rst = 0;
        chk("rw_div_x", div_x, 0);
        chk("rw_div_y", div_y, 0);
        chk("rw_signed", div_signed, 0);
        chk("rw_busy", busy, 0);
        chk("rw_rsp_valid", rsp_valid, 0);

        // Reset mid-RESP with a divide-by-zero response held.
        rsp_ready = 0;
        issue(2'b00, 32'd9, 32'd0, 5'd13);
        step;
        req_valid = 0;
        step; step;
        chk("rr_rsp_dz_pre", rsp_dz, 1);
        rst = 1;
        step;
        rst = 0;
        chk("rr_rsp_valid", rsp_valid, 0);
        chk("rr_rsp_data", rsp_data, 0);
        chk("rr_rsp_tag", rsp_tag, 0);
        chk("rr_rsp_dz", rsp_dz, 0);
        chk("rr_busy", busy, 0);

        // LAT=1 instance after reset.
        req_op = 2'b00; req_x = 32'd100; req_y = 32'd7; req_tag = 5'd21; req_valid1 = 1;
        #1 chk("l1_req_ready", req_ready1, 1);
        step;
        req_valid1 = 0;
        chk("l1_busy", busy1, 1);
        chk("l1_early", rsp_valid1, 0);
        step;
        chk("l1_rsp_valid", rsp_valid1, 1);
        chk("l1_rsp_data", rsp_data1, 32'd14);
        chk("l1_rsp_tag", rsp_tag1, 21);
        step;
        chk("l1_drained", rsp_valid1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
